// File: rtl/instr_queue.sv
// rtl/instr_queue.sv - fetch queue: issues imem reads, buffers {pc, instr} for decode, flushes on jump.
module instr_queue #(
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [31:0]   pc_i,
  input  logic          pc_jump_i,
  output logic          imem_req_o,
  output logic [31:0]   imem_addr_o,
  input  logic [31:0]   imem_rdata_i,
  output logic          fetch_stall_o,
  output logic          id_valid_o,
  input  logic          id_ready_i,
  output logic [31:0]   id_pc_o,
  output logic [31:0]   id_instr_o,
  output logic [AW:0]   count_o
);

  localparam int DEPTH = 1 << AW;

  logic [AW:0]   count;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          inflight;
  logic [31:0]   pc_q;
  logic [31:0]   pc_mem    [DEPTH];
  logic [31:0]   instr_mem [DEPTH];

  logic [AW+1:0] occupancy;
  logic          space;
  logic          push;
  logic          pop;

  // The outstanding read reserves a slot; a pop in the same cycle is not credited.
  assign occupancy = {1'b0, count} + {{(AW+1){1'b0}}, inflight};
  assign space     = occupancy < (AW+2)'(DEPTH);

  assign imem_req_o    = rst_n & ~pc_jump_i & space;
  assign imem_addr_o   = pc_i;
  assign fetch_stall_o = ~pc_jump_i & ~space;

  assign id_valid_o = (count != '0);
  assign id_pc_o    = id_valid_o ? pc_mem[rd_ptr]    : 32'h0;
  assign id_instr_o = id_valid_o ? instr_mem[rd_ptr] : 32'h0;
  assign count_o    = count;

  assign push = inflight & ~pc_jump_i;
  assign pop  = id_valid_o & id_ready_i & ~pc_jump_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      inflight <= 1'b0;
      pc_q     <= 32'h0;
    end else if (pc_jump_i) begin
      // Flush drops queued entries and the response returning this cycle.
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      inflight <= 1'b0;
    end else begin
      inflight <= imem_req_o;
      if (imem_req_o) begin
        pc_q <= pc_i;
      end
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]    <= pc_q;
      instr_mem[wr_ptr] <= imem_rdata_i;
    end
  end

endmodule

// File: doc/instr_queue.md
Name: instr_queue

Overview:
- Fetch-side stage directly downstream of the PC generator.
- Each cycle it issues a read of the presented PC to a synchronous instruction memory with 1-cycle read latency.
- It captures the returned instruction together with its PC into a FIFO of 2^AW entries and hands {pc, instr} to decode over a valid/ready handshake.
- A jump flushes all queued and in-flight fetches and drives back-pressure toward the PC generator.

Parameters:
- AW, 4: FIFO address width; DEPTH = 2^AW entries (default 16).

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- pc_i  in  32  current fetch PC from PC generator
- pc_jump_i  in  1  redirect/flush; same signal that loads the jump target into the PC
- imem_req_o  out  1  instruction memory read enable for address pc_i this cycle
- imem_addr_o  out  32  memory address, equals pc_i
- imem_rdata_i  in  32  instruction data, valid the cycle after imem_req_o
- fetch_stall_o  out  1  upstream must hold pc_i this cycle
- id_valid_o  out  1  head entry valid toward decode
- id_ready_i  in  1  decode accepts head entry
- id_pc_o  out  32  PC of head entry
- id_instr_o  out  32  instruction of head entry
- count_o  out  AW+1  number of occupied FIFO entries (0..DEPTH)

Behaviour:
- Reset (async, rst_n=0):
  - count, read pointer, write pointer, in-flight flag and captured PC all clear to 0.
  - id_valid_o=0, count_o=0, imem_req_o=0.
  - id_pc_o and id_instr_o drive 0 while empty.
- space = (count + inflight) < DEPTH. A same-cycle pop is NOT credited (conservative).
- imem_req_o = rst_n & ~pc_jump_i & space. This is combinational and imem_addr_o = pc_i.
- fetch_stall_o = ~pc_jump_i & ~space. During a jump cycle the PC loads the target regardless, so no stall is signalled.
- In-flight stage, one register pair (inflight, pc_q):
  - On imem_req_o: inflight<=1, pc_q<=pc_i.
  - Otherwise: inflight<=0.
- Push:
  - Occurs when inflight=1 and pc_jump_i=0.
  - Writes {pc_q, imem_rdata_i} at the write pointer; the write pointer increments.
- Pop:
  - Occurs when id_valid_o & id_ready_i; the read pointer increments.
- Latency: pc_i requested in cycle N → instruction returns in cycle N+1 → entry visible with id_valid_o=1 in cycle N+2. There is no bypass of the empty FIFO.
- Output: id_valid_o = (count != 0). id_pc_o/id_instr_o are read combinationally from the head entry.
- Pointers are AW bits and wrap modulo DEPTH (DEPTH-1 → 0).
- Count update:
  - Push and pop in the same cycle: count unchanged.
  - Push only: +1.
  - Pop only: -1.
  - Push while count=DEPTH cannot occur, because space gating guarantees it.
- Flush (pc_jump_i=1), effective at the clock edge:
  - count<=0, both pointers<=0, inflight<=0.
  - The in-flight response is discarded, and any pop in that cycle is ignored.
  - In the flush cycle itself, id_valid_o still reflects pre-flush state; decode may observe a wrong-path handshake, which decode must also drop on pc_jump_i.
- Back-to-back jumps: each jump cycle suppresses the request. The first request after the last jump fetches the final target.
- Steady state with id_ready_i=1: one instruction per cycle; the FIFO holds 1 entry.

Test Plan:
- Reset then free-run from PC 0 with id_ready_i=1, memory returning instr=pc^0xA5A5A5A5 → id_valid_o first high in cycle 2 with id_pc_o=0; thereafter the PC advances by 4 each cycle and instr matches.
- id_ready_i=0 from reset (AW=4) → requests stop once count+inflight=16. count_o saturates at 16, fetch_stall_o=1, entries 0x00..0x3C are queued in order; releasing ready drains them in order with no loss or duplication.
- Jump to 0x100 while count=5 and inflight=1 → next cycle count_o=0, id_valid_o=0. The discarded response is never visible, and the first entry delivered has id_pc_o=0x100.
- Simultaneous push and pop at count=16→15 refill and at count=1 → count_o unchanged. Pointer wrap from 15→0 preserves order across ≥40 entries.
- Two consecutive jump cycles (0x200 then 0x300) → only entries from 0x300 onward ever appear on id_pc_o.
- Assert rst_n low mid-stream with count=7 → all outputs go to 0 immediately (asynchronously). After release, fetch resumes from PC 0 with a 2-cycle valid latency.
